truth_table_sequencer: RTL and testbench

Synthesizable exhaustive-test controller for small combinational blocks such as the three-input, two-output teaching circuits in this codebase. On `start` it drives every input combination 0 … 2^N_IN−1 onto the device under test in turn. After a programmable settle time it samples the DUT outputs and compares them against a parameterised expected truth table. It reports pass/fail, the error count and the first failing vector, replacing the loop-and-display bench style with an on-chip sequencer.

---
 rtl/truth_table_sequencer.sv | 141 ++++++++++++++
 tb/tb_truth_table_sequencer.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/truth_table_sequencer.sv
// rtl/truth_table_sequencer.sv - exhaustive truth-table test sequencer for small combinational blocks
//
// Walks every input combination 0 .. 2^N_IN-1 onto a combinational DUT. Each
// vector is held for SETTLE cycles, then sampled once, and the sampled response
// is compared against the matching slice of the EXPECT table.
//
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous active-high reset
//   start       begin a run (sampled only in IDLE)
//   abort       cancel a run in progress (SETTLE or CAPTURE)
//   stim        registered stimulus to the DUT inputs, MSB = first DUT input
//   resp        DUT outputs
//   busy        high while a run is in progress
//   done        one-cycle pulse when a run completes normally
//   pass        last completed run had zero mismatches; held until next start
//   err_count   mismatching vectors in the current/last run
//   fail_valid  at least one mismatch in this run
//   fail_idx    stimulus value of the first mismatch
module truth_table_sequencer #(
  parameter int N_IN   = 3,
  parameter int N_OUT  = 2,
  parameter int SETTLE = 2,
  parameter logic [(2**N_IN)*N_OUT-1:0] EXPECT = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  output logic [N_IN-1:0]  stim,
  input  logic [N_OUT-1:0] resp,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [N_IN:0]    err_count,
  output logic             fail_valid,
  output logic [N_IN-1:0]  fail_idx
);

  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(SETTLE - 1);
  localparam logic [N_IN-1:0]  LAST_VEC   = {N_IN{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_CAPTURE,
    S_DONE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [N_OUT-1:0] expect_slice;
  logic             mismatch;

  always_comb begin
    expect_slice = EXPECT[int'(stim) * N_OUT +: N_OUT];
  end

  // Case inequality so that an undriven or X response is reported as a
  // mismatch rather than silently treated as a match.
  assign mismatch = (resp !== expect_slice);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      stim       <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= '0;
      fail_valid <= 1'b0;
      fail_idx   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          // abort is deliberately not looked at here: start wins
          if (start) begin
            state      <= S_SETTLE;
            stim       <= '0;
            cnt        <= CNT_RELOAD;
            busy       <= 1'b1;
            pass       <= 1'b0;
            err_count  <= '0;
            fail_valid <= 1'b0;
            fail_idx   <= '0;
          end
        end

        S_SETTLE: begin
          if (abort) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else if (cnt == '0) begin
            state <= S_CAPTURE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        S_CAPTURE: begin
          // an abort in the capture cycle drops this vector uncompared
          if (abort) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            if (mismatch) begin
              err_count <= err_count + 1'b1;
              if (!fail_valid) begin
                fail_valid <= 1'b1;
                fail_idx   <= stim;
              end
            end
            if (stim == LAST_VEC) begin
              // pass must include the final vector's own comparison
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (err_count == '0) && !mismatch;
            end else begin
              stim  <= stim + 1'b1;
              cnt   <= CNT_RELOAD;
              state <= S_SETTLE;
            end
          end
        end

        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_sequencer.sv
// tb/tb_truth_table_sequencer.sv - scoreboard bench for truth_table_sequencer
module tb_truth_table_sequencer;

  // Full-adder truth table, {sum, carry} per vector k = {A,B,C}, k = 7 down to 0
  localparam logic [15:0] GOLD = 16'b11_01_01_10_01_10_10_00;

  logic clk = 1'b0;
  logic reset, start, abort;
  logic fault;

  logic [2:0] stim_a, stim_b;
  logic [1:0] resp_a, resp_b;
  logic       busy_a, done_a, pass_a, fail_valid_a;
  logic       busy_b, done_b, pass_b, fail_valid_b;
  logic [3:0] err_count_a, err_count_b;
  logic [2:0] fail_idx_a, fail_idx_b;

  always #5 clk = ~clk;

  // behavioral device under test: full adder, E (carry) optionally corrupted for inputs 5 and 6
  function automatic logic [1:0] adder(input logic [2:0] v);
    logic d, e;
    d = v[2] ^ v[1] ^ v[0];
    e = (v[2] & v[1]) | (v[0] & (v[2] ^ v[1]));
    return {d, e};
  endfunction

  always_comb begin
    resp_a = adder(stim_a) ^ ((fault && (stim_a == 3'd5 || stim_a == 3'd6)) ? 2'b01 : 2'b00);
    resp_b = adder(stim_b) ^ ((fault && (stim_b == 3'd5 || stim_b == 3'd6)) ? 2'b01 : 2'b00);
  end

  truth_table_sequencer #(.N_IN(3), .N_OUT(2), .SETTLE(2), .EXPECT(GOLD)) dut_a (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .stim(stim_a), .resp(resp_a), .busy(busy_a), .done(done_a), .pass(pass_a),
    .err_count(err_count_a), .fail_valid(fail_valid_a), .fail_idx(fail_idx_a)
  );

  truth_table_sequencer #(.N_IN(3), .N_OUT(2), .SETTLE(1), .EXPECT(GOLD)) dut_b (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .stim(stim_b), .resp(resp_b), .busy(busy_b), .done(done_b), .pass(pass_b),
    .err_count(err_count_b), .fail_valid(fail_valid_b), .fail_idx(fail_idx_b)
  );

  typedef struct {
    int v;
    int c;
  } obs_t;

  obs_t exp_q[$];
  int   done_q[$];
  int   busy_fall;
  int   overlap;
  int   n_vec = 0;
  int   n_err = 0;

  // Push expected (stimulus, edge) pairs; edge 1 is the edge that accepts start.
  task automatic push_run(input int period, input int last_k);
    for (int k = 0; k <= last_k; k++) begin
      obs_t e;
      e.v = k;
      e.c = 1 + k * period;
      exp_q.push_back(e);
    end
  endtask

  // Monitor one run for 30 edges. start (and abort) are assumed raised at the
  // preceding negedge. act_kind 1 = pulse abort, 2 = pulse start, once the
  // selected instance is observed driving act_stim.
  task automatic watch(input bit sel, input int act_stim, input int act_kind);
    logic [2:0] s_stim, p_stim;
    logic s_busy, s_done, p_busy;
    int pend;
    bit acted;
    obs_t e;
    done_q.delete();
    busy_fall = 0;
    overlap   = 0;
    pend      = 0;
    acted     = 0;
    p_busy    = 1'b0;
    p_stim    = '0;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk);
      #1;
      s_stim = sel ? stim_b : stim_a;
      s_busy = sel ? busy_b : busy_a;
      s_done = sel ? done_b : done_a;
      if (s_busy && (!p_busy || s_stim != p_stim)) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL vector_extra: got stim %0d at edge %0d, expected none", s_stim, c);
        end else begin
          e = exp_q.pop_front();
          if (s_stim !== 3'(e.v) || c != e.c) begin
            n_err++;
            $display("FAIL vector: got stim %0d at edge %0d, expected stim %0d at edge %0d",
                     s_stim, c, e.v, e.c);
          end
        end
      end
      if (s_done === 1'b1) done_q.push_back(c);
      if (s_busy === 1'b1 && s_done === 1'b1) overlap++;
      if (p_busy && !s_busy) busy_fall = c;
      p_busy = s_busy;
      p_stim = s_stim;
      #4;
      if (c == 1) begin
        start = 1'b0;
        abort = 1'b0;
      end
      if (pend == 1) begin
        start = 1'b0;
        abort = 1'b0;
        pend  = 0;
      end
      if (act_kind != 0 && !acted && s_busy && s_stim == 3'(act_stim)) begin
        acted = 1;
        pend  = 1;
        if (act_kind == 1) abort = 1'b1;
        else start = 1'b1;
      end
    end
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL vectors_missing: got %0d unseen, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    fault = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if ({stim_a, busy_a, done_a, pass_a, err_count_a, fail_valid_a, fail_idx_a} !== 15'd0) begin
      n_err++;
      $display("FAIL reset_a: got %h, expected 0",
               {stim_a, busy_a, done_a, pass_a, err_count_a, fail_valid_a, fail_idx_a});
    end
    n_vec++;
    if ({stim_b, busy_b, done_b, pass_b, err_count_b, fail_valid_b, fail_idx_b} !== 15'd0) begin
      n_err++;
      $display("FAIL reset_b: got %h, expected 0",
               {stim_b, busy_b, done_b, pass_b, err_count_b, fail_valid_b, fail_idx_b});
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_golden;
    push_run(3, 7);
    start = 1'b1;
    watch(1'b0, 0, 0);
    n_vec++;
    if (done_q.size() != 1 || done_q[0] != 25) begin
      n_err++;
      $display("FAIL golden_done: got %0d pulses first at %0d, expected 1 at 25",
               done_q.size(), (done_q.size() > 0) ? done_q[0] : -1);
    end
    n_vec++;
    if (pass_a !== 1'b1 || err_count_a !== 4'd0 || fail_valid_a !== 1'b0) begin
      n_err++;
      $display("FAIL golden_result: got pass %b err %0d fv %b, expected 1 0 0",
               pass_a, err_count_a, fail_valid_a);
    end
    n_vec++;
    if (busy_fall != 25 || overlap != 0) begin
      n_err++;
      $display("FAIL golden_busy: got fall %0d overlap %0d, expected 25 0", busy_fall, overlap);
    end
  endtask

  task automatic test_settle1;
    // start and abort together in IDLE must still start the run
    push_run(2, 7);
    start = 1'b1;
    abort = 1'b1;
    watch(1'b1, 0, 0);
    n_vec++;
    if (done_q.size() != 1 || done_q[0] != 17) begin
      n_err++;
      $display("FAIL settle1_done: got %0d pulses first at %0d, expected 1 at 17",
               done_q.size(), (done_q.size() > 0) ? done_q[0] : -1);
    end
    n_vec++;
    if (pass_b !== 1'b1 || err_count_b !== 4'd0 || busy_fall != 17) begin
      n_err++;
      $display("FAIL settle1_result: got pass %b err %0d fall %0d, expected 1 0 17",
               pass_b, err_count_b, busy_fall);
    end
  endtask

  task automatic test_fault;
    fault = 1'b1;
    push_run(3, 7);
    start = 1'b1;
    watch(1'b0, 0, 0);
    fault = 1'b0;
    n_vec++;
    if (err_count_a !== 4'd2 || fail_valid_a !== 1'b1 || fail_idx_a !== 3'd5 || pass_a !== 1'b0) begin
      n_err++;
      $display("FAIL fault_result: got err %0d fv %b idx %0d pass %b, expected 2 1 5 0",
               err_count_a, fail_valid_a, fail_idx_a, pass_a);
    end
    n_vec++;
    if (done_q.size() != 1 || done_q[0] != 25) begin
      n_err++;
      $display("FAIL fault_done: got %0d pulses, expected 1 at 25", done_q.size());
    end
  endtask

  task automatic test_abort;
    push_run(3, 3);
    start = 1'b1;
    watch(1'b0, 3, 1);
    n_vec++;
    if (done_q.size() != 0 || busy_fall != 11 || busy_a !== 1'b0 || pass_a !== 1'b0) begin
      n_err++;
      $display("FAIL abort_state: got done %0d fall %0d busy %b pass %b, expected 0 11 0 0",
               done_q.size(), busy_fall, busy_a, pass_a);
    end
    n_vec++;
    if (stim_a !== 3'd3 || err_count_a !== 4'd0) begin
      n_err++;
      $display("FAIL abort_partial: got stim %0d err %0d, expected 3 0", stim_a, err_count_a);
    end
    push_run(3, 7);
    start = 1'b1;
    watch(1'b0, 0, 0);
    n_vec++;
    if (pass_a !== 1'b1 || err_count_a !== 4'd0 || done_q.size() != 1 || done_q[0] != 25) begin
      n_err++;
      $display("FAIL abort_restart: got pass %b err %0d done %0d, expected 1 0 1",
               pass_a, err_count_a, done_q.size());
    end
  endtask

  task automatic test_busy_start;
    push_run(3, 7);
    start = 1'b1;
    watch(1'b0, 4, 2);
    n_vec++;
    if (done_q.size() != 1 || done_q[0] != 25 || pass_a !== 1'b1) begin
      n_err++;
      $display("FAIL busy_start: got %0d done pulses first at %0d pass %b, expected 1 at 25 pass 1",
               done_q.size(), (done_q.size() > 0) ? done_q[0] : -1, pass_a);
    end
  endtask

  task automatic test_reset_mid_run;
    bit found;
    fault = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (busy_a === 1'b1 && stim_a === 3'd6) found = 1;
      else @(negedge clk);
    end
    n_vec++;
    if (!found || err_count_a !== 4'd1 || fail_idx_a !== 3'd5) begin
      n_err++;
      $display("FAIL midrun_reach: got found %0d err %0d idx %0d, expected 1 1 5",
               found, err_count_a, fail_idx_a);
    end
    reset = 1'b1;
    #1;
    n_vec++;
    if ({stim_a, busy_a, done_a, pass_a, err_count_a, fail_valid_a, fail_idx_a} !== 15'd0) begin
      n_err++;
      $display("FAIL midrun_async_reset: got %h, expected 0",
               {stim_a, busy_a, done_a, pass_a, err_count_a, fail_valid_a, fail_idx_a});
    end
    @(negedge clk);
    reset = 1'b0;
    fault = 1'b0;
    push_run(3, 7);
    start = 1'b1;
    watch(1'b0, 0, 0);
    n_vec++;
    if (pass_a !== 1'b1 || err_count_a !== 4'd0 || done_q.size() != 1) begin
      n_err++;
      $display("FAIL midrun_restart: got pass %b err %0d done %0d, expected 1 0 1",
               pass_a, err_count_a, done_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_golden();
    test_settle1();
    test_fault();
    test_abort();
    test_busy_start();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
